buffer_escritura_memoria: RTL

//  Store path into the data memory: the writer side of the read-select path on the memory output.

---
 rtl/buffer_escritura_memoria_pkg.sv | 20 ++
 rtl/buffer_escritura_memoria_alineador.sv | 42 ++++
 rtl/buffer_escritura_memoria.sv | 126 ++++++++++++
 3 files changed

// File: rtl/buffer_escritura_memoria_pkg.sv
// Shared definitions for the data-memory store path.
// Size codes, address width and the buffered store entry record.
package paquete_memoria;

    // Byte-address width the entry record is built for.
    // The top-level ADDR_W parameter must match this value.
    localparam int ANCHO_DIR = 32;

    localparam logic [1:0] TAM_BYTE    = 2'b00;
    localparam logic [1:0] TAM_MEDIO   = 2'b01;
    localparam logic [1:0] TAM_PALABRA = 2'b10;

    // One buffered store: word address, lane data, byte enables.
    typedef struct packed {
        logic [ANCHO_DIR-1:2] dir_palabra;
        logic [31:0]          dato;
        logic [3:0]           bytes;
    } entrada_t;

endpackage

// File: rtl/buffer_escritura_memoria_alineador.sv
// Store alignment: places store data into byte lanes and builds enables.
// Ports: direccion_i, dato_i, tamano_i -> entrada_o (aligned entry), error_o.
module alineador_escritura
    import paquete_memoria::*;
(
    input  logic [ANCHO_DIR-1:0] direccion_i,
    input  logic [31:0]          dato_i,
    input  logic [1:0]           tamano_i,
    output entrada_t             entrada_o,
    output logic                 error_o
);

    logic [1:0] a;

    assign a = direccion_i[1:0];

    always_comb begin
        entrada_o             = '0;
        error_o               = 1'b0;
        entrada_o.dir_palabra = direccion_i[ANCHO_DIR-1:2];
        unique case (tamano_i)
            TAM_BYTE: begin
                entrada_o.bytes = 4'b0001 << a;
                entrada_o.dato  = {4{dato_i[7:0]}};
            end
            TAM_MEDIO: begin
                error_o         = a[0];
                entrada_o.bytes = a[1] ? 4'b1100 : 4'b0011;
                entrada_o.dato  = {2{dato_i[15:0]}};
            end
            TAM_PALABRA: begin
                error_o         = (a != 2'b00);
                entrada_o.bytes = 4'b1111;
                entrada_o.dato  = dato_i;
            end
            default: begin
                error_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/buffer_escritura_memoria.sv
// Store buffer in front of the data memory: aligns core stores and
// drains them in order through a DEPTH-entry FIFO.
// Ports: Clock, Reset_n (sync, active-low); core side Escribir_valido/
// Escribir_listo, Direccion, Dato, Tamano; memory side Mem_valido/
// Mem_listo, Mem_direccion, Mem_dato, Mem_habilitar_bytes; status
// Vacio, Ocupacion, Error_alineacion.
module buffer_escritura_memoria
    import paquete_memoria::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ANCHO_DIR
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   Escribir_valido,
    output logic                   Escribir_listo,
    input  logic [ADDR_W-1:0]      Direccion,
    input  logic [31:0]            Dato,
    input  logic [1:0]             Tamano,
    output logic                   Mem_valido,
    input  logic                   Mem_listo,
    output logic [ADDR_W-1:0]      Mem_direccion,
    output logic [31:0]            Mem_dato,
    output logic [3:0]             Mem_habilitar_bytes,
    output logic                   Vacio,
    output logic [$clog2(DEPTH):0] Ocupacion,
    output logic                   Error_alineacion
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entrada_t        mem_q [DEPTH];
    entrada_t        entrada;
    entrada_t        cabeza;
    logic            error_al;

    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            lleno;
    logic            vacio;
    logic            acepta;
    logic            push;
    logic            pop;

    alineador_escritura u_alineador (
        .direccion_i (Direccion),
        .dato_i      (Dato),
        .tamano_i    (Tamano),
        .entrada_o   (entrada),
        .error_o     (error_al)
    );

    // Ready depends only on the count, never on Mem_listo, so a pop
    // in the same cycle cannot open a slot in a full buffer.
    assign lleno  = (cnt_q == CW'(DEPTH));
    assign vacio  = (cnt_q == '0);
    assign acepta = Escribir_valido && !lleno;
    // A rejected request completes the handshake but stores nothing.
    assign push   = acepta && !error_al;
    assign pop    = !vacio && Mem_listo;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        err_d = acepta && error_al;
        if (push) begin
            wr_d = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Storage holds no reset; validity is tracked by the count alone.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem_q[wr_q] <= entrada;
        end
    end

    assign cabeza = mem_q[rd_q];

    // Head fields are gated to zero so stale storage never shows
    // on the memory bus while the buffer is empty.
    always_comb begin
        Mem_direccion       = '0;
        Mem_dato            = '0;
        Mem_habilitar_bytes = '0;
        if (!vacio) begin
            Mem_direccion       = {cabeza.dir_palabra, 2'b00};
            Mem_dato            = cabeza.dato;
            Mem_habilitar_bytes = cabeza.bytes;
        end
    end

    assign Escribir_listo   = !lleno;
    assign Mem_valido       = !vacio;
    assign Vacio            = vacio;
    assign Ocupacion        = cnt_q;
    assign Error_alineacion = err_q;

endmodule
